// File: rtl/fm_add_ddr_arbiter.sv
// fm_add_ddr_arbiter
//   Shares the single MIG-style app_* port of the DDR wrapper between NUM_CH
//   fm_add DDR movers. Start pulses are latched, ownership is handed out
//   round-robin, and ownership is only released once every read the owner
//   issued has returned, so read data can never be routed to the wrong mover.
//
// Ports
//   clk, rst                  ui_clk and asynchronous active-low reset
//   ch_req / ch_done          per-channel start / completion pulses
//   ch_app_*  (inputs)        flattened per-channel MIG request buses
//   ch_app_*  (outputs)       ready/valid strobes gated to the owner only,
//                             read data broadcast
//   app_*                     MIG port towards fm_add_ddr_wrapper_top
//   init_calib_complete       no new grant while low
//   grant_valid / grant_id    current owner
//   outstd_cnt                reads issued but not yet returned
//   err_underflow             sticky: read return seen with nothing in flight
module fm_add_ddr_arbiter #(
    parameter int NUM_CH         = 3,
    parameter int APP_ADDR_WIDTH = 32,
    parameter int APP_DATA_WIDTH = 64,
    parameter int APP_MASK_WIDTH = APP_DATA_WIDTH / 8,
    parameter int MAX_OUTSTD     = 16,
    parameter int CH_W           = $clog2(NUM_CH)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CH-1:0]                  ch_req,
    input  logic [NUM_CH-1:0]                  ch_done,
    input  logic [NUM_CH*APP_ADDR_WIDTH-1:0]   ch_app_addr,
    input  logic [NUM_CH*3-1:0]                ch_app_cmd,
    input  logic [NUM_CH-1:0]                  ch_app_en,
    input  logic [NUM_CH*APP_DATA_WIDTH-1:0]   ch_app_wdf_data,
    input  logic [NUM_CH-1:0]                  ch_app_wdf_end,
    input  logic [NUM_CH*APP_MASK_WIDTH-1:0]   ch_app_wdf_mask,
    input  logic [NUM_CH-1:0]                  ch_app_wdf_wren,
    output logic [NUM_CH-1:0]                  ch_app_rdy,
    output logic [NUM_CH-1:0]                  ch_app_wdf_rdy,
    output logic [APP_DATA_WIDTH-1:0]          ch_app_rd_data,
    output logic [NUM_CH-1:0]                  ch_app_rd_data_valid,
    output logic [NUM_CH-1:0]                  ch_app_rd_data_end,
    output logic [APP_ADDR_WIDTH-1:0]          app_addr,
    output logic [2:0]                         app_cmd,
    output logic                               app_en,
    output logic [APP_DATA_WIDTH-1:0]          app_wdf_data,
    output logic                               app_wdf_end,
    output logic [APP_MASK_WIDTH-1:0]          app_wdf_mask,
    output logic                               app_wdf_wren,
    input  logic [APP_DATA_WIDTH-1:0]          app_rd_data,
    input  logic                               app_rd_data_end,
    input  logic                               app_rd_data_valid,
    input  logic                               app_rdy,
    input  logic                               app_wdf_rdy,
    input  logic                               init_calib_complete,
    output logic                               grant_valid,
    output logic [CH_W-1:0]                    grant_id,
    output logic [$clog2(MAX_OUTSTD):0]        outstd_cnt,
    output logic                               err_underflow
);

    localparam int         CNT_W    = $clog2(MAX_OUTSTD) + 1;
    localparam logic [2:0] CMD_READ = 3'b001;

    typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

    state_t                state, state_next;
    logic [NUM_CH-1:0]     pending;
    logic [NUM_CH-1:0]     req_vec;
    logic [NUM_CH-1:0]     sel_oh;
    logic [NUM_CH-1:0]     owner_oh;
    logic [CH_W-1:0]       last_id;
    logic [CH_W-1:0]       sel;
    logic                  sel_found;
    logic                  grant_start;
    logic                  owner_done;
    logic [CNT_W-1:0]      cnt_next;
    logic                  underflow_evt;
    logic                  rd_issue;
    logic                  read_block;

    logic [APP_ADDR_WIDTH-1:0] own_addr;
    logic [2:0]                own_cmd;
    logic                      own_en;
    logic [APP_DATA_WIDTH-1:0] own_wdf_data;
    logic                      own_wdf_end;
    logic [APP_MASK_WIDTH-1:0] own_wdf_mask;
    logic                      own_wdf_wren;

    // A request pulse in the same cycle as an idle arbitration is considered
    // directly, giving one cycle from ch_req to grant_valid.
    assign req_vec = pending | ch_req;

    // Round-robin: first requester above last_id, otherwise wrap to the
    // lowest requester.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!sel_found && req_vec[i] && (CH_W'(i) > last_id)) begin
                sel       = CH_W'(i);
                sel_found = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!sel_found && req_vec[i]) begin
                sel       = CH_W'(i);
                sel_found = 1'b1;
            end
        end
        sel_oh = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            sel_oh[i] = (sel == CH_W'(i));
        end
    end

    assign grant_start = (state == IDLE) && sel_found && init_calib_complete;

    // Owner's request bus.
    always_comb begin
        owner_oh     = '0;
        own_addr     = '0;
        own_cmd      = '0;
        own_en       = 1'b0;
        own_wdf_data = '0;
        own_wdf_end  = 1'b0;
        own_wdf_mask = '0;
        own_wdf_wren = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (grant_id == CH_W'(i)) begin
                owner_oh[i]  = 1'b1;
                own_addr     = ch_app_addr[i*APP_ADDR_WIDTH +: APP_ADDR_WIDTH];
                own_cmd      = ch_app_cmd[i*3 +: 3];
                own_en       = ch_app_en[i];
                own_wdf_data = ch_app_wdf_data[i*APP_DATA_WIDTH +: APP_DATA_WIDTH];
                own_wdf_end  = ch_app_wdf_end[i];
                own_wdf_mask = ch_app_wdf_mask[i*APP_MASK_WIDTH +: APP_MASK_WIDTH];
                own_wdf_wren = ch_app_wdf_wren[i];
            end
        end
    end

    // Only reads are throttled by the in-flight limit; writes never return data.
    assign read_block = (outstd_cnt == CNT_W'(MAX_OUTSTD)) && (own_cmd == CMD_READ);
    assign owner_done = |(ch_done & owner_oh);

    always_comb begin
        app_addr             = '0;
        app_cmd              = '0;
        app_en               = 1'b0;
        app_wdf_data         = '0;
        app_wdf_end          = 1'b0;
        app_wdf_mask         = '0;
        app_wdf_wren         = 1'b0;
        ch_app_rdy           = '0;
        ch_app_wdf_rdy       = '0;
        ch_app_rd_data_valid = '0;
        ch_app_rd_data_end   = '0;
        ch_app_rd_data       = '0;
        case (state)
            GRANT: begin
                app_addr             = own_addr;
                app_cmd              = own_cmd;
                app_en               = own_en & ~read_block;
                app_wdf_data         = own_wdf_data;
                app_wdf_end          = own_wdf_end;
                app_wdf_mask         = own_wdf_mask;
                app_wdf_wren         = own_wdf_wren;
                ch_app_rdy           = owner_oh & {NUM_CH{app_rdy & ~read_block}};
                ch_app_wdf_rdy       = owner_oh & {NUM_CH{app_wdf_rdy}};
                ch_app_rd_data_valid = owner_oh & {NUM_CH{app_rd_data_valid}};
                ch_app_rd_data_end   = owner_oh & {NUM_CH{app_rd_data_end}};
                ch_app_rd_data       = app_rd_data;
            end
            DRAIN: begin
                ch_app_rd_data_valid = owner_oh & {NUM_CH{app_rd_data_valid}};
                ch_app_rd_data_end   = owner_oh & {NUM_CH{app_rd_data_end}};
                ch_app_rd_data       = app_rd_data;
            end
            default: ;
        endcase
    end

    // Outstanding-read accounting.
    assign rd_issue = app_en & app_rdy & (app_cmd == CMD_READ);

    always_comb begin
        cnt_next      = outstd_cnt;
        underflow_evt = 1'b0;
        if (rd_issue && !app_rd_data_valid) begin
            cnt_next = outstd_cnt + 1'b1;
        end else if (!rd_issue && app_rd_data_valid) begin
            if (outstd_cnt == '0) begin
                underflow_evt = 1'b1;
            end else begin
                cnt_next = outstd_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_start) state_next = GRANT;
            GRANT:   if (owner_done) state_next = (cnt_next != '0) ? DRAIN : IDLE;
            DRAIN:   if (cnt_next == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending       <= '0;
            grant_id      <= '0;
            last_id       <= CH_W'(NUM_CH - 1);
            outstd_cnt    <= '0;
            err_underflow <= 1'b0;
        end else begin
            pending    <= req_vec & ~(grant_start ? sel_oh : '0);
            outstd_cnt <= cnt_next;
            if (grant_start) begin
                grant_id <= sel;
                last_id  <= sel;
            end
            if (underflow_evt) begin
                err_underflow <= 1'b1;
            end
        end
    end

    assign grant_valid = (state != IDLE);

endmodule

// File: tb/tb_fm_add_ddr_arbiter.sv
// tb_fm_add_ddr_arbiter
//   Directed bench for fm_add_ddr_arbiter. Two instances share all inputs:
//   dut (MAX_OUTSTD=16) for most scenarios and dut_lim (MAX_OUTSTD=4) for
//   the in-flight read limit. Inputs change on the falling edge.
module tb_fm_add_ddr_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   ch_req, ch_done, ch_app_en, ch_app_wdf_end, ch_app_wdf_wren;
    logic [95:0]  ch_app_addr;
    logic [8:0]   ch_app_cmd;
    logic [191:0] ch_app_wdf_data;
    logic [23:0]  ch_app_wdf_mask;
    logic [63:0]  app_rd_data;
    logic         app_rd_data_end, app_rd_data_valid, app_rdy, app_wdf_rdy;
    logic         init_calib_complete;

    logic [2:0]   ch_app_rdy, ch_app_wdf_rdy, ch_app_rd_data_valid, ch_app_rd_data_end;
    logic [63:0]  ch_app_rd_data, app_wdf_data;
    logic [31:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en, app_wdf_end, app_wdf_wren, grant_valid, err_underflow;
    logic [7:0]   app_wdf_mask;
    logic [1:0]   grant_id;
    logic [4:0]   outstd_cnt;

    logic [2:0]   l_ch_app_rdy, l_ch_app_wdf_rdy, l_ch_app_rd_data_valid, l_ch_app_rd_data_end;
    logic [63:0]  l_ch_app_rd_data, l_app_wdf_data;
    logic [31:0]  l_app_addr;
    logic [2:0]   l_app_cmd;
    logic         l_app_en, l_app_wdf_end, l_app_wdf_wren, l_grant_valid, l_err_underflow;
    logic [7:0]   l_app_wdf_mask;
    logic [1:0]   l_grant_id;
    logic [2:0]   l_outstd_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fm_add_ddr_arbiter #(.NUM_CH(3), .MAX_OUTSTD(16)) dut (
        .clk(clk), .rst(rst), .ch_req(ch_req), .ch_done(ch_done),
        .ch_app_addr(ch_app_addr), .ch_app_cmd(ch_app_cmd), .ch_app_en(ch_app_en),
        .ch_app_wdf_data(ch_app_wdf_data), .ch_app_wdf_end(ch_app_wdf_end),
        .ch_app_wdf_mask(ch_app_wdf_mask), .ch_app_wdf_wren(ch_app_wdf_wren),
        .ch_app_rdy(ch_app_rdy), .ch_app_wdf_rdy(ch_app_wdf_rdy),
        .ch_app_rd_data(ch_app_rd_data), .ch_app_rd_data_valid(ch_app_rd_data_valid),
        .ch_app_rd_data_end(ch_app_rd_data_end), .app_addr(app_addr), .app_cmd(app_cmd),
        .app_en(app_en), .app_wdf_data(app_wdf_data), .app_wdf_end(app_wdf_end),
        .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
        .app_rd_data(app_rd_data), .app_rd_data_end(app_rd_data_end),
        .app_rd_data_valid(app_rd_data_valid), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
        .init_calib_complete(init_calib_complete), .grant_valid(grant_valid),
        .grant_id(grant_id), .outstd_cnt(outstd_cnt), .err_underflow(err_underflow)
    );

    fm_add_ddr_arbiter #(.NUM_CH(3), .MAX_OUTSTD(4)) dut_lim (
        .clk(clk), .rst(rst), .ch_req(ch_req), .ch_done(ch_done),
        .ch_app_addr(ch_app_addr), .ch_app_cmd(ch_app_cmd), .ch_app_en(ch_app_en),
        .ch_app_wdf_data(ch_app_wdf_data), .ch_app_wdf_end(ch_app_wdf_end),
        .ch_app_wdf_mask(ch_app_wdf_mask), .ch_app_wdf_wren(ch_app_wdf_wren),
        .ch_app_rdy(l_ch_app_rdy), .ch_app_wdf_rdy(l_ch_app_wdf_rdy),
        .ch_app_rd_data(l_ch_app_rd_data), .ch_app_rd_data_valid(l_ch_app_rd_data_valid),
        .ch_app_rd_data_end(l_ch_app_rd_data_end), .app_addr(l_app_addr), .app_cmd(l_app_cmd),
        .app_en(l_app_en), .app_wdf_data(l_app_wdf_data), .app_wdf_end(l_app_wdf_end),
        .app_wdf_mask(l_app_wdf_mask), .app_wdf_wren(l_app_wdf_wren),
        .app_rd_data(app_rd_data), .app_rd_data_end(app_rd_data_end),
        .app_rd_data_valid(app_rd_data_valid), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
        .init_calib_complete(init_calib_complete), .grant_valid(l_grant_valid),
        .grant_id(l_grant_id), .outstd_cnt(l_outstd_cnt), .err_underflow(l_err_underflow)
    );

    task automatic clear_inputs;
        ch_req = '0; ch_done = '0; ch_app_en = '0; ch_app_wdf_end = '0; ch_app_wdf_wren = '0;
        ch_app_addr = '0; ch_app_cmd = '0; ch_app_wdf_data = '0; ch_app_wdf_mask = '0;
        app_rd_data = '0; app_rd_data_end = 1'b0; app_rd_data_valid = 1'b0;
        app_rdy = 1'b0; app_wdf_rdy = 1'b0; init_calib_complete = 1'b1;
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic pulse_done(input int ch);
        ch_done = '0;
        ch_done[ch] = 1'b1;
        step();
        ch_done = '0;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1'b0;
        ch_app_en = 3'b111; app_rdy = 1'b1; app_rd_data = 64'hDEAD_BEEF_0000_0001;
        #1;
        n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL reset_grant_valid: got %0h expected 0", grant_valid); end
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0h expected 0", grant_id); end
        n_checks++; if (outstd_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_outstd: got %0h expected 0", outstd_cnt); end
        n_checks++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0h expected 0", err_underflow); end
        n_checks++; if (app_en !== 1'b0) begin n_fail++; $display("FAIL reset_app_en: got %0h expected 0", app_en); end
        n_checks++; if (ch_app_rdy !== 3'b000) begin n_fail++; $display("FAIL reset_ch_rdy: got %0h expected 0", ch_app_rdy); end
        n_checks++; if (ch_app_rd_data !== 64'd0) begin n_fail++; $display("FAIL reset_rd_data: got %0h expected 0", ch_app_rd_data); end
        do_reset();
    endtask

    task automatic test_single_channel;
        do_reset();
        ch_req = 3'b010;
        step();
        ch_req = '0;
        #1;
        n_checks++; if (grant_valid !== 1'b1) begin n_fail++; $display("FAIL single_grant_valid: got %0h expected 1", grant_valid); end
        n_checks++; if (grant_id !== 2'd1) begin n_fail++; $display("FAIL single_grant_id: got %0h expected 1", grant_id); end
        ch_app_en[1] = 1'b1; ch_app_cmd[5:3] = 3'b001; app_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ch_app_addr[63:32] = 32'h0000_1000 + 32'(k);
            #1;
            n_checks++; if (app_addr !== 32'h0000_1000 + 32'(k)) begin n_fail++; $display("FAIL single_addr: got %0h expected %0h", app_addr, 32'h1000 + k); end
            n_checks++; if (ch_app_rdy !== 3'b010) begin n_fail++; $display("FAIL single_ch_rdy: got %0h expected 2", ch_app_rdy); end
            step();
        end
        ch_app_en = '0;
        #1;
        n_checks++; if (outstd_cnt !== 5'd4) begin n_fail++; $display("FAIL single_outstd_peak: got %0d expected 4", outstd_cnt); end
        for (int k = 0; k < 4; k++) begin
            app_rd_data_valid = 1'b1; app_rd_data = 64'hA5A5_0000_0000_0000 + 64'(k);
            #1;
            n_checks++; if (ch_app_rd_data_valid !== 3'b010) begin n_fail++; $display("FAIL single_rd_valid: got %0h expected 2", ch_app_rd_data_valid); end
            n_checks++; if (ch_app_rd_data !== 64'hA5A5_0000_0000_0000 + 64'(k)) begin n_fail++; $display("FAIL single_rd_data: got %0h", ch_app_rd_data); end
            step();
        end
        app_rd_data_valid = 1'b0;
        #1;
        n_checks++; if (outstd_cnt !== 5'd0) begin n_fail++; $display("FAIL single_outstd_end: got %0d expected 0", outstd_cnt); end
        pulse_done(1);
        #1;
        n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL single_release: got %0h expected 0", grant_valid); end
    endtask

    task automatic test_round_robin;
        do_reset();
        ch_req = 3'b111;
        step();
        ch_req = '0;
        #1;
        n_checks++; if (grant_id !== 2'd0 || grant_valid !== 1'b1) begin n_fail++; $display("FAIL rr_first: got id %0d valid %0h expected id 0 valid 1", grant_id, grant_valid); end
        pulse_done(0);
        #1;
        n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL rr_idle0: got %0h expected 0", grant_valid); end
        step();
        n_checks++; if (grant_id !== 2'd1 || grant_valid !== 1'b1) begin n_fail++; $display("FAIL rr_second: got id %0d valid %0h expected id 1 valid 1", grant_id, grant_valid); end
        pulse_done(1);
        step();
        n_checks++; if (grant_id !== 2'd2 || grant_valid !== 1'b1) begin n_fail++; $display("FAIL rr_third: got id %0d valid %0h expected id 2 valid 1", grant_id, grant_valid); end
        ch_req = 3'b010;
        step();
        ch_req = '0;
        pulse_done(2);
        #1;
        n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL rr_idle2: got %0h expected 0", grant_valid); end
        step();
        n_checks++; if (grant_id !== 2'd1 || grant_valid !== 1'b1) begin n_fail++; $display("FAIL rr_wrap: got id %0d valid %0h expected id 1 valid 1", grant_id, grant_valid); end
        pulse_done(1);
    endtask

    task automatic test_early_done;
        do_reset();
        ch_req = 3'b001;
        step();
        ch_req = 3'b100;
        ch_app_en[0] = 1'b1; ch_app_cmd[2:0] = 3'b001; app_rdy = 1'b1;
        step();
        ch_req = '0;
        for (int k = 0; k < 7; k++) step();
        ch_app_en = '0;
        #1;
        n_checks++; if (outstd_cnt !== 5'd8) begin n_fail++; $display("FAIL early_outstd8: got %0d expected 8", outstd_cnt); end
        app_rd_data_valid = 1'b1;
        for (int k = 0; k < 3; k++) step();
        app_rd_data_valid = 1'b0;
        pulse_done(0);
        ch_app_en[0] = 1'b1; ch_app_wdf_wren[0] = 1'b1;
        #1;
        n_checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin n_fail++; $display("FAIL early_drain_owner: got valid %0h id %0d expected valid 1 id 0", grant_valid, grant_id); end
        n_checks++; if (outstd_cnt !== 5'd5) begin n_fail++; $display("FAIL early_drain_cnt: got %0d expected 5", outstd_cnt); end
        n_checks++; if (app_en !== 1'b0 || app_wdf_wren !== 1'b0 || ch_app_rdy !== 3'b000) begin n_fail++; $display("FAIL early_drain_block: got en %0h wren %0h rdy %0h expected 0 0 0", app_en, app_wdf_wren, ch_app_rdy); end
        app_rd_data_valid = 1'b1;
        #1;
        n_checks++; if (ch_app_rd_data_valid !== 3'b001) begin n_fail++; $display("FAIL early_drain_route: got %0h expected 1", ch_app_rd_data_valid); end
        for (int k = 0; k < 4; k++) step();
        n_checks++; if (grant_valid !== 1'b1 || outstd_cnt !== 5'd1) begin n_fail++; $display("FAIL early_still_drain: got valid %0h cnt %0d expected 1 1", grant_valid, outstd_cnt); end
        step();
        app_rd_data_valid = 1'b0; ch_app_en = '0; ch_app_wdf_wren = '0;
        #1;
        n_checks++; if (grant_valid !== 1'b0 || outstd_cnt !== 5'd0) begin n_fail++; $display("FAIL early_idle: got valid %0h cnt %0d expected 0 0", grant_valid, outstd_cnt); end
        step();
        n_checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd2) begin n_fail++; $display("FAIL early_next_grant: got valid %0h id %0d expected 1 2", grant_valid, grant_id); end
        pulse_done(2);
    endtask

    task automatic test_outstanding_limit;
        do_reset();
        ch_req = 3'b001;
        step();
        ch_req = '0;
        ch_app_en[0] = 1'b1; ch_app_cmd[2:0] = 3'b001; app_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++; if (l_app_en !== 1'b1 || l_ch_app_rdy !== 3'b001) begin n_fail++; $display("FAIL limit_accept: got en %0h rdy %0h expected 1 1", l_app_en, l_ch_app_rdy); end
            step();
        end
        #1;
        n_checks++; if (l_outstd_cnt !== 3'd4) begin n_fail++; $display("FAIL limit_cnt_full: got %0d expected 4", l_outstd_cnt); end
        n_checks++; if (l_app_en !== 1'b0 || l_ch_app_rdy !== 3'b000) begin n_fail++; $display("FAIL limit_block: got en %0h rdy %0h expected 0 0", l_app_en, l_ch_app_rdy); end
        step();
        step();
        n_checks++; if (l_outstd_cnt !== 3'd4 || l_app_en !== 1'b0) begin n_fail++; $display("FAIL limit_hold: got cnt %0d en %0h expected 4 0", l_outstd_cnt, l_app_en); end
        ch_app_cmd[2:0] = 3'b000;
        #1;
        n_checks++; if (l_app_en !== 1'b1 || l_ch_app_rdy !== 3'b001) begin n_fail++; $display("FAIL limit_write_pass: got en %0h rdy %0h expected 1 1", l_app_en, l_ch_app_rdy); end
        step();
        ch_app_cmd[2:0] = 3'b001;
        app_rd_data_valid = 1'b1;
        step();
        app_rd_data_valid = 1'b0;
        #1;
        n_checks++; if (l_outstd_cnt !== 3'd3 || l_app_en !== 1'b1) begin n_fail++; $display("FAIL limit_reopen: got cnt %0d en %0h expected 3 1", l_outstd_cnt, l_app_en); end
        step();
        n_checks++; if (l_outstd_cnt !== 3'd4 || l_app_en !== 1'b0) begin n_fail++; $display("FAIL limit_fifth: got cnt %0d en %0h expected 4 0", l_outstd_cnt, l_app_en); end
        ch_app_en = '0;
    endtask

    task automatic test_isolation;
        do_reset();
        ch_req = 3'b010;
        step();
        ch_req = '0;
        ch_app_cmd = 9'b001_001_001; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        ch_app_en = 3'b101;
        ch_app_addr = {32'h2222_0000, 32'h1111_0000, 32'hAAAA_0000};
        #1;
        n_checks++; if (app_en !== 1'b0) begin n_fail++; $display("FAIL iso_en_nonowner: got %0h expected 0", app_en); end
        n_checks++; if (ch_app_rdy !== 3'b010 || ch_app_wdf_rdy !== 3'b010) begin n_fail++; $display("FAIL iso_rdy: got rdy %0h wdf_rdy %0h expected 2 2", ch_app_rdy, ch_app_wdf_rdy); end
        n_checks++; if (app_addr !== 32'h1111_0000) begin n_fail++; $display("FAIL iso_addr: got %0h expected 11110000", app_addr); end
        step();
        ch_app_en = 3'b111;
        #1;
        n_checks++; if (app_en !== 1'b1) begin n_fail++; $display("FAIL iso_en_owner: got %0h expected 1", app_en); end
        step();
        ch_app_en = '0;
        app_rd_data_valid = 1'b1; app_rd_data_end = 1'b1;
        #1;
        n_checks++; if (ch_app_rd_data_valid !== 3'b010 || ch_app_rd_data_end !== 3'b010) begin n_fail++; $display("FAIL iso_rd_route: got valid %0h end %0h expected 2 2", ch_app_rd_data_valid, ch_app_rd_data_end); end
        step();
        app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
        ch_done = 3'b101;
        step();
        ch_done = '0;
        #1;
        n_checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd1) begin n_fail++; $display("FAIL iso_foreign_done: got valid %0h id %0d expected 1 1", grant_valid, grant_id); end
        ch_app_cmd = 9'b001_000_001;
        ch_app_wdf_data = {64'h3333, 64'h0123_4567_89AB_CDEF, 64'h1111};
        ch_app_wdf_mask = {8'hFF, 8'h0F, 8'hAA};
        ch_app_wdf_wren = 3'b011; ch_app_wdf_end = 3'b011;
        #1;
        n_checks++; if (app_wdf_data !== 64'h0123_4567_89AB_CDEF || app_wdf_mask !== 8'h0F) begin n_fail++; $display("FAIL iso_wdata: got data %0h mask %0h expected 0123456789abcdef 0f", app_wdf_data, app_wdf_mask); end
        n_checks++; if (app_wdf_wren !== 1'b1 || app_wdf_end !== 1'b1 || app_cmd !== 3'b000) begin n_fail++; $display("FAIL iso_wctrl: got wren %0h end %0h cmd %0h expected 1 1 0", app_wdf_wren, app_wdf_end, app_cmd); end
        ch_app_wdf_wren = '0; ch_app_wdf_end = '0;
        pulse_done(1);
    endtask

    task automatic test_calib;
        do_reset();
        init_calib_complete = 1'b0;
        ch_req = 3'b100;
        step();
        ch_req = '0;
        #1;
        n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL calib_block: got %0h expected 0", grant_valid); end
        init_calib_complete = 1'b1;
        step();
        n_checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd2) begin n_fail++; $display("FAIL calib_grant: got valid %0h id %0d expected 1 2", grant_valid, grant_id); end
        init_calib_complete = 1'b0;
        step();
        n_checks++; if (grant_valid !== 1'b1) begin n_fail++; $display("FAIL calib_keep: got %0h expected 1", grant_valid); end
        init_calib_complete = 1'b1;
        pulse_done(2);
    endtask

    task automatic test_reset_error;
        do_reset();
        ch_req = 3'b001;
        step();
        ch_req = '0;
        ch_app_en[0] = 1'b1; ch_app_cmd[2:0] = 3'b001; app_rdy = 1'b1;
        for (int k = 0; k < 3; k++) step();
        n_checks++; if (outstd_cnt !== 5'd3 || grant_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre: got cnt %0d valid %0h expected 3 1", outstd_cnt, grant_valid); end
        #2 rst = 1'b0;
        #1;
        n_checks++; if (grant_valid !== 1'b0 || outstd_cnt !== 5'd0) begin n_fail++; $display("FAIL rst_async: got valid %0h cnt %0d expected 0 0", grant_valid, outstd_cnt); end
        n_checks++; if (app_en !== 1'b0 || ch_app_rdy !== 3'b000) begin n_fail++; $display("FAIL rst_async_out: got en %0h rdy %0h expected 0 0", app_en, ch_app_rdy); end
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        app_rd_data_valid = 1'b1;
        #1;
        n_checks++; if (ch_app_rd_data_valid !== 3'b000) begin n_fail++; $display("FAIL err_drop: got %0h expected 0", ch_app_rd_data_valid); end
        step();
        app_rd_data_valid = 1'b0;
        #1;
        n_checks++; if (err_underflow !== 1'b1 || outstd_cnt !== 5'd0) begin n_fail++; $display("FAIL err_set: got err %0h cnt %0d expected 1 0", err_underflow, outstd_cnt); end
        for (int k = 0; k < 3; k++) step();
        n_checks++; if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %0h expected 1", err_underflow); end
        do_reset();
        #1;
        n_checks++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %0h expected 0", err_underflow); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_channel();
        test_round_robin();
        test_early_done();
        test_outstanding_limit();
        test_isolation();
        test_calib();
        test_reset_error();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
